// File: rtl/write_merge_buffer_pkg.sv
// Shared types for the write-combining buffer.
// Line/mask types and the drain state machine encoding.
package write_merge_buffer_pkg;

    localparam int LC3B_LINE_W = 128;

    typedef logic [LC3B_LINE_W-1:0]   lc3b_c_line;
    typedef logic [LC3B_LINE_W/8-1:0] lc3b_c_mask;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        FLUSH
    } wmb_state_t;

endpackage

// File: rtl/wmb_lane_steer.sv
// Word-to-line steering for one CPU store.
// Places the store bytes in their line lanes and builds the byte mask.
module wmb_lane_steer #(
    parameter int LINE_W = 128,
    parameter int IDX_W  = 3
) (
    input  logic [IDX_W-1:0]    word_idx,
    input  logic [15:0]         data,
    input  logic [1:0]          be,
    output logic [LINE_W-1:0]   line_data,
    output logic [LINE_W/8-1:0] line_mask
);

    logic [IDX_W+3:0] lo_bit;
    logic [IDX_W+3:0] hi_bit;
    logic [IDX_W:0]   lo_byte;
    logic [IDX_W:0]   hi_byte;

    assign lo_bit  = {word_idx, 4'b0000};
    assign hi_bit  = {word_idx, 4'b1000};
    assign lo_byte = {word_idx, 1'b0};
    assign hi_byte = {word_idx, 1'b1};

    // A single-byte store always carries its byte in data[7:0].
    always_comb begin
        line_data = '0;
        line_mask = '0;
        unique case (be)
            2'b11: begin
                line_data[lo_bit +: 8] = data[7:0];
                line_data[hi_bit +: 8] = data[15:8];
                line_mask[lo_byte]     = 1'b1;
                line_mask[hi_byte]     = 1'b1;
            end
            2'b01: begin
                line_data[lo_bit +: 8] = data[7:0];
                line_mask[lo_byte]     = 1'b1;
            end
            2'b10: begin
                line_data[hi_bit +: 8] = data[7:0];
                line_mask[hi_byte]     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/write_merge_buffer.sv
// Write-combining buffer between the store path and the masked line write port.
// Optional idle drain enabled by defining WMB_IDLE_DRAIN_EN.
module write_merge_buffer
    import write_merge_buffer_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int WORD_W      = 16,
    parameter int LINE_W      = 128,
    parameter int DEPTH       = 4,
    parameter int IDLE_CYCLES = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_req,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [WORD_W-1:0]        wr_data,
    input  logic [1:0]               wr_be,
    output logic                     wr_ack,
    input  logic                     flush_req,
    output logic                     flush_done,
    input  logic [ADDR_W-1:0]        probe_addr,
    output logic                     probe_hit,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ADDR_W-1:0]        out_addr,
    output logic [LINE_W-1:0]        out_data,
    output logic [LINE_W/8-1:0]      out_mask,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int OFF_W  = $clog2(LINE_W/8);
    localparam int TAG_W  = ADDR_W - OFF_W;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int OCC_W  = PTR_W + 1;
    localparam int MASK_W = LINE_W / 8;
    localparam logic [OCC_W-1:0] FULL = OCC_W'(DEPTH);

    logic [DEPTH-1:0]  ent_valid;
    logic [TAG_W-1:0]  ent_tag  [DEPTH];
    logic [LINE_W-1:0] ent_data [DEPTH];
    logic [MASK_W-1:0] ent_mask [DEPTH];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [OCC_W-1:0] occ_next;
    wmb_state_t       state;
    wmb_state_t       state_next;
    logic             flush_pend;
    logic             flush_pend_next;
    logic             flush_done_next;

    logic [LINE_W-1:0] st_data;
    logic [MASK_W-1:0] st_mask;
    logic [TAG_W-1:0]  wr_tag;
    logic [TAG_W-1:0]  probe_tag;
    logic [DEPTH-1:0]  hit_vec;
    logic [DEPTH-1:0]  probe_vec;
    logic [PTR_W-1:0]  hit_idx;
    logic              hit_any;
    logic              head_lock;
    logic              noop;
    logic              full;
    logic              accept;
    logic              merge;
    logic              push;
    logic              pop;
    logic              idle_fire;
    logic              unused_bits;

    assign unused_bits = ^{wr_addr[0], probe_addr[OFF_W-1:0],
                           IDLE_CYCLES[0]};

    wmb_lane_steer #(
        .LINE_W (LINE_W),
        .IDX_W  (OFF_W - 1)
    ) u_steer (
        .word_idx  (wr_addr[OFF_W-1:1]),
        .data      (wr_data),
        .be        (wr_be),
        .line_data (st_data),
        .line_mask (st_mask)
    );

    assign wr_tag    = wr_addr[ADDR_W-1:OFF_W];
    assign probe_tag = probe_addr[ADDR_W-1:OFF_W];

    // Tag compare for the store and the read-conflict probe.
    always_comb begin
        hit_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hit_vec[i]   = ent_valid[i] && ent_tag[i] == wr_tag;
            probe_vec[i] = ent_valid[i] && ent_tag[i] == probe_tag;
            if (hit_vec[i]) hit_idx = PTR_W'(i);
        end
    end

    assign hit_any   = |hit_vec;
    assign probe_hit = |probe_vec;
    assign full      = occupancy == FULL;
    assign out_valid = state != IDLE && occupancy != '0;
    assign pop       = out_valid && out_ready;

    // The presented head must not change under the consumer.
    assign head_lock = hit_any && hit_idx == head && out_valid;
    assign noop      = wr_be == 2'b00;
    assign accept    = wr_req && !wr_ack &&
                       (noop || (hit_any && !head_lock) ||
                        (!hit_any && !full));
    assign merge     = accept && !noop && hit_any;
    assign push      = accept && !noop && !hit_any;
    assign occ_next  = occupancy + OCC_W'(push) - OCC_W'(pop);

    assign out_addr  = {ent_tag[head], {OFF_W{1'b0}}};
    assign out_data  = ent_data[head];
    assign out_mask  = ent_mask[head];

    // Entry valid bits, pointers, count and handshake pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            ent_valid  <= '0;
            head       <= '0;
            tail       <= '0;
            occupancy  <= '0;
            wr_ack     <= 1'b0;
            flush_done <= 1'b0;
            flush_pend <= 1'b0;
            state      <= IDLE;
        end else begin
            if (push) ent_valid[tail] <= 1'b1;
            if (pop)  ent_valid[head] <= 1'b0;
            tail       <= tail + PTR_W'(push);
            head       <= head + PTR_W'(pop);
            occupancy  <= occ_next;
            wr_ack     <= accept;
            flush_done <= flush_done_next;
            flush_pend <= flush_pend_next;
            state      <= state_next;
        end
    end

    // Line payloads: allocate at tail or merge enabled bytes into a hit.
    always_ff @(posedge clk) begin
        if (push) begin
            ent_tag[tail]  <= wr_tag;
            ent_data[tail] <= st_data;
            ent_mask[tail] <= st_mask;
        end else if (merge) begin
            ent_mask[hit_idx] <= ent_mask[hit_idx] | st_mask;
            for (int b = 0; b < MASK_W; b++) begin
                if (st_mask[b])
                    ent_data[hit_idx][b*8 +: 8] <= st_data[b*8 +: 8];
            end
        end
    end

`ifdef WMB_IDLE_DRAIN_EN
    localparam int CNT_W = $clog2(IDLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(IDLE_CYCLES - 1);

    logic [CNT_W-1:0] idle_cnt;

    assign idle_fire = state == IDLE && !accept &&
                       occupancy != '0 && idle_cnt == CNT_TOP;

    // Counts quiet cycles while data sits in the buffer.
    always_ff @(posedge clk) begin
        if (reset || accept || pop || idle_fire)
            idle_cnt <= '0;
        else if (occupancy != '0 && idle_cnt != CNT_TOP)
            idle_cnt <= idle_cnt + 1'b1;
    end
`else
    assign idle_fire = 1'b0;
`endif

    // Drain state machine: full drain, flush and idle drain.
    always_comb begin
        state_next      = state;
        flush_pend_next = flush_pend;
        flush_done_next = 1'b0;
        unique case (state)
            IDLE: begin
                if (flush_req) begin
                    if (occ_next == '0) flush_done_next = 1'b1;
                    else                state_next      = FLUSH;
                end else if (full || idle_fire) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (flush_req) flush_pend_next = 1'b1;
                if (pop) begin
                    if (flush_pend || flush_req) begin
                        state_next      = FLUSH;
                        flush_pend_next = 1'b0;
                    end else if (occ_next != FULL) begin
                        state_next = IDLE;
                    end
                end
            end
            FLUSH: begin
                if (occ_next == '0) begin
                    flush_done_next = 1'b1;
                    state_next      = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule
